// File: rtl/angle_pkg.sv
// rtl/angle_pkg.sv - shared widths, FSM states and switch decoding for angle entry
package angle_pkg;

  localparam int DEG_MOD = 360;
  localparam int ACC_W   = 14;
  localparam int DEG_W   = 9;
  localparam int BCD_W   = 4;

  typedef enum logic [1:0] {IDLE, CONV, MOD} state_t;

  typedef struct packed {
    logic             valid;
    logic [BCD_W-1:0] value;
  } sw_t;

  // Switches are active-low; anything above 9 is not a decimal digit.
  function automatic sw_t decode_switch(input logic [BCD_W-1:0] sw_n);
    sw_t r;
    r.value = ~sw_n;
    r.valid = (r.value <= 4'd9);
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronizes, debounces and edge-detects the active-low push button
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_evt;
  logic             w_pressed;

  assign w_pressed = ~r_sync1;
  assign press_evt = r_evt;

  // The state flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
      r_state <= 1'b0;
      r_cnt   <= '0;
      r_evt   <= 1'b0;
    end else begin
      r_sync0 <= btn;
      r_sync1 <= r_sync0;
      r_evt   <= 1'b0;
      if (w_pressed == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_state <= w_pressed;
        r_cnt   <= '0;
        r_evt   <= w_pressed;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/angle_entry.sv
// rtl/angle_entry.sv - four-digit BCD entry register with serial BCD-to-binary and modulo-360 reduction
import angle_pkg::*;

module angle_entry #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BCD_W-1:0] digit,
  input  logic             btn,
  output logic [BCD_W-1:0] d3,
  output logic [BCD_W-1:0] d2,
  output logic [BCD_W-1:0] d1,
  output logic [BCD_W-1:0] d0,
  output logic [DEG_W-1:0] deg,
  output logic             deg_valid,
  output logic             busy,
  output logic             entry_err
);

  state_t           r_state;
  logic [BCD_W-1:0] r_d [4];
  logic [ACC_W-1:0] r_acc;
  logic [1:0]       r_idx;
  logic [DEG_W-1:0] r_deg;
  logic             r_deg_valid;
  logic             r_busy;
  logic             r_entry_err;
  logic             w_press_evt;
  sw_t              w_sw;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .press_evt(w_press_evt)
  );

  assign w_sw      = decode_switch(digit);
  assign d3        = r_d[3];
  assign d2        = r_d[2];
  assign d1        = r_d[1];
  assign d0        = r_d[0];
  assign deg       = r_deg;
  assign deg_valid = r_deg_valid;
  assign busy      = r_busy;
  assign entry_err = r_entry_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_d[0]      <= '0;
      r_d[1]      <= '0;
      r_d[2]      <= '0;
      r_d[3]      <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_deg       <= '0;
      r_deg_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_entry_err <= 1'b0;
    end else begin
      r_deg_valid <= 1'b0;
      r_entry_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_press_evt) begin
            if (w_sw.valid) begin
              r_d[3]  <= r_d[2];
              r_d[2]  <= r_d[1];
              r_d[1]  <= r_d[0];
              r_d[0]  <= w_sw.value;
              r_acc   <= '0;
              r_idx   <= 2'd3;
              r_busy  <= 1'b1;
              r_state <= CONV;
            end else begin
              r_entry_err <= 1'b1;
            end
          end
        end
        // Horner step, thousands digit first: acc*10 built from two shifts.
        CONV: begin
          r_acc <= (r_acc << 3) + (r_acc << 1) + ACC_W'(r_d[r_idx]);
          r_idx <= r_idx - 2'd1;
          if (r_idx == 2'd0) begin
            r_state <= MOD;
          end
        end
        MOD: begin
          if (r_acc >= ACC_W'(DEG_MOD)) begin
            r_acc <= r_acc - ACC_W'(DEG_MOD);
          end else begin
            r_deg       <= r_acc[DEG_W-1:0];
            r_deg_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_angle_entry.sv
// tb/tb_angle_entry.sv - scoreboard bench for angle_entry with directed digit entries
module tb_angle_entry;

  logic       clk;
  logic       rst;
  logic [3:0] digit;
  logic       btn;
  logic [3:0] d3, d2, d1, d0;
  logic [8:0] deg;
  logic       deg_valid;
  logic       busy;
  logic       entry_err;

  angle_entry #(.DEBOUNCE_CYCLES(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .digit    (digit),
    .btn      (btn),
    .d3       (d3),
    .d2       (d2),
    .d1       (d1),
    .d0       (d0),
    .deg      (deg),
    .deg_valid(deg_valid),
    .busy     (busy),
    .entry_err(entry_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int deg;
    int lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  int   shift_cyc = 0;
  bit   prev_busy = 0;
  int   m[4];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic chk_digits();
    chk("d3", d3, m[3]);
    chk("d2", d2, m[2]);
    chk("d1", d1, m[1]);
    chk("d0", d0, m[0]);
  endtask

  // Monitor: pops one expectation for every deg_valid or entry_err cycle.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst) begin
      prev_busy = 0;
    end else begin
      if (busy && !prev_busy) shift_cyc = ncyc;
      prev_busy = busy;
      if (deg_valid || entry_err) begin
        if (q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          e = q.pop_front();
          chk("event_kind", int'(entry_err), int'(e.is_err));
          chk("event_single", int'(deg_valid && entry_err), 0);
          if (!e.is_err) begin
            chk("deg", deg, e.deg);
            chk("latency", ncyc - shift_cyc, e.lat);
          end
        end
      end
    end
  end

  task automatic model_shift(input int val);
    m[3] = m[2];
    m[2] = m[1];
    m[1] = m[0];
    m[0] = val;
  endtask

  task automatic expect_entry(input int val);
    exp_t e;
    int   v;
    if (val <= 9) begin
      model_shift(val);
      v = m[3] * 1000 + m[2] * 100 + m[1] * 10 + m[0];
      e.is_err = 0;
      e.deg    = v % 360;
      e.lat    = 5 + v / 360;
    end else begin
      e.is_err = 1;
      e.deg    = 0;
      e.lat    = 0;
    end
    q.push_back(e);
  endtask

  task automatic press(input int val);
    logic [3:0] v4;
    v4    = val[3:0];
    digit = ~v4;
    expect_entry(val);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    btn = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    logic [3:0] v4;
    bit         seen;
    for (int i = 0; i < 4; i++) m[i] = 0;
    rst   = 1'b1;
    btn   = 1'b1;
    digit = 4'b1111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_deg", deg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_deg_valid", deg_valid, 0);
    chk("rst_entry_err", entry_err, 0);
    chk_digits();
    repeat (50) @(negedge clk);

    press(0);
    press(3);
    press(6);
    press(5);
    chk_digits();
    chk("deg_365", deg, 5);

    btn = 1'b0; repeat (5) @(negedge clk);
    btn = 1'b1; repeat (3) @(negedge clk);
    btn = 1'b0; repeat (5) @(negedge clk);
    btn = 1'b1; repeat (30) @(negedge clk);
    chk_digits();
    chk("bounce_busy", busy, 0);
    press(2);
    chk_digits();

    for (int i = 0; i < 4; i++) press(9);
    chk_digits();
    chk("deg_9999", deg, 279);
    press(1);
    chk_digits();
    chk("deg_9991", deg, 271);

    press(10);
    chk_digits();
    chk("invalid_busy", busy, 0);
    chk("invalid_deg", deg, 271);

    for (int i = 0; i < 3; i++) press(9);
    v4    = 4'd9;
    digit = ~v4;
    model_shift(9);
    btn  = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    btn = 1'b1;
    chk("midop_busy_seen", int'(seen), 1);
    chk_digits();
    repeat (14) @(negedge clk);
    chk("midop_still_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = 0;
    chk_digits();
    chk("midop_deg", deg, 0);
    chk("midop_busy", busy, 0);
    repeat (60) @(negedge clk);
    chk("post_rst_busy", busy, 0);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("pending_events", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
